// File: rtl/physical_iob_clk_ctrl.sv
// Forwarded-clock controller for an ODDR: parks the line low when idle, warms up before ready, cools down after.
// Optional session counter on o_start_cnt is enabled by defining PHYSICAL_IOB_CLK_CTRL_START_CNT_EN.
module physical_iob_clk_ctrl #(
  parameter int WARMUP_CYCLES   = 64,
  parameter int COOLDOWN_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic        o_oddr_d1,
  output logic        o_oddr_d2,
  output logic        o_oddr_ce,
  output logic        o_busy,
  output logic        o_ready,
  output logic [15:0] o_start_cnt
);

  localparam int MAX_CYCLES = (WARMUP_CYCLES > COOLDOWN_CYCLES) ? WARMUP_CYCLES : COOLDOWN_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP_CYCLES);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WARMUP   = 2'd1;
  localparam logic [1:0] S_RUN      = 2'd2;
  localparam logic [1:0] S_COOLDOWN = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_d1;
  logic          r_d2;
  logic          r_ce;
  logic          r_busy;
  logic          r_ready;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_en) begin
          w_state_next = S_WARMUP;
          w_cnt_next   = '0;
        end
      end
      S_WARMUP: begin
        if (!i_en) begin
          w_state_next = S_COOLDOWN;
          w_cnt_next   = '0;
        end else if (r_cnt == WARM_LAST) begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!i_en) begin
          w_state_next = S_COOLDOWN;
          w_cnt_next   = '0;
        end
      end
      S_COOLDOWN: begin
        // The clock never stopped, so a new request skips warm-up, even on the final count.
        if (i_en) begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
        end else if (r_cnt == COOL_LAST) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as r_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_d1    <= 1'b0;
      r_d2    <= 1'b0;
      r_ce    <= 1'b1;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_d1    <= (w_state_next != S_IDLE);
      r_d2    <= 1'b0;
      r_ce    <= 1'b1;
      r_busy  <= (w_state_next != S_IDLE);
      r_ready <= (w_state_next == S_RUN);
    end
  end

`ifdef PHYSICAL_IOB_CLK_CTRL_START_CNT_EN
  logic [15:0] r_start_cnt;
  logic        w_start;

  assign w_start = (r_state == S_IDLE) && (w_state_next == S_WARMUP);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_start_cnt <= '0;
    end else if (w_start && (r_start_cnt != 16'hFFFF)) begin
      r_start_cnt <= r_start_cnt + 16'd1;
    end
  end

  assign o_start_cnt = r_start_cnt;
`else
  assign o_start_cnt = '0;
`endif

  assign o_oddr_d1 = r_d1;
  assign o_oddr_d2 = r_d2;
  assign o_oddr_ce = r_ce;
  assign o_busy    = r_busy;
  assign o_ready   = r_ready;

endmodule

// File: tb/tb_physical_iob_clk_ctrl.sv
// Directed bench for physical_iob_clk_ctrl with WARMUP_CYCLES=8, COOLDOWN_CYCLES=4.
// "Edge k" values are read 1 ns after posedge k; inputs change there too, so edge k samples them next.
module tb_physical_iob_clk_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        d1;
  logic        d2;
  logic        ce;
  logic        busy;
  logic        ready;
  logic [15:0] start_cnt;

  int n_vec;
  int n_bad;
  int n_starts;
  logic [15:0] saved_cnt;

  physical_iob_clk_ctrl #(
    .WARMUP_CYCLES  (8),
    .COOLDOWN_CYCLES(4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .o_oddr_d1  (d1),
    .o_oddr_d2  (d2),
    .o_oddr_ce  (ce),
    .o_busy     (busy),
    .o_ready    (ready),
    .o_start_cnt(start_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_start(input int n);
`ifdef PHYSICAL_IOB_CLK_CTRL_START_CNT_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  // IDLE request sampled at edge 0: ready only at edge 9.
  task automatic warm_up(input string tag);
    en = 1'b1;
    tick();
    n_starts++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk({tag, "_ready_lo"}, {15'd0, ready}, 16'd0);
      if (k == 1) begin
        chk({tag, "_busy_e1"}, {15'd0, busy}, 16'd1);
        chk({tag, "_d1_e1"}, {15'd0, d1}, 16'd1);
      end
    end
    tick();
    chk({tag, "_ready_e9"}, {15'd0, ready}, 16'd1);
    $display("warm-up %s: ready=%0b start_cnt=%0d", tag, ready, start_cnt);
  endtask

  // Drop sampled at edge N: clock held through N+4, parked at N+5.
  task automatic cool_down(input string tag);
    en = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk({tag, "_cd_d1"}, {15'd0, d1}, 16'd1);
      chk({tag, "_cd_ready"}, {15'd0, ready}, 16'd0);
    end
    tick();
    chk({tag, "_idle_d1"}, {15'd0, d1}, 16'd0);
    chk({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
    $display("cool-down %s: d1=%0b busy=%0b", tag, d1, busy);
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    n_starts = 0;
    rst      = 1'b1;
    en       = 1'b0;
    tick();
    tick();
    chk("rst_d1", {15'd0, d1}, 16'd0);
    chk("rst_d2", {15'd0, d2}, 16'd0);
    chk("rst_ce", {15'd0, ce}, 16'd1);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_ready", {15'd0, ready}, 16'd0);
    chk("rst_start", start_cnt, 16'd0);
    $display("reset: d1=%0b ce=%0b busy=%0b ready=%0b", d1, ce, busy, ready);

    rst = 1'b0;
    tick();
    chk("idle_d1", {15'd0, d1}, 16'd0);
    warm_up("s1");
    chk("run_d2", {15'd0, d2}, 16'd0);
    chk("run_ce", {15'd0, ce}, 16'd1);
    chk("s1_start", start_cnt, exp_start(n_starts));
    en = 1'b0;
    tick();
    chk("drop_ready_n1", {15'd0, ready}, 16'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("drop_d1", {15'd0, d1}, 16'd1);
    end
    tick();
    chk("drop_d1_n4", {15'd0, d1}, 16'd1);
    chk("drop_busy_n4", {15'd0, busy}, 16'd1);
    tick();
    chk("drop_d1_n5", {15'd0, d1}, 16'd0);
    chk("drop_busy_n5", {15'd0, busy}, 16'd0);
    $display("run drop: d1=%0b busy=%0b", d1, busy);

    // Abort warm-up after three cycles.
    en = 1'b1;
    tick();
    n_starts++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("abort_warm_ready", {15'd0, ready}, 16'd0);
    end
    cool_down("abort");
    chk("abort_start", start_cnt, exp_start(n_starts));

    // Re-request in cooldown cycle 2: straight back to RUN, no new session.
    warm_up("s3");
    saved_cnt = start_cnt;
    en = 1'b0;
    tick();
    tick();
    en = 1'b1;
    tick();
    chk("reenter_ready", {15'd0, ready}, 16'd1);
    chk("reenter_start", start_cnt, saved_cnt);
    $display("cooldown re-entry: ready=%0b start_cnt=%0d", ready, start_cnt);

    // Request on the final cooldown count wins over returning to IDLE.
    en = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) tick();
    chk("final_cnt_busy", {15'd0, busy}, 16'd1);
    en = 1'b1;
    tick();
    chk("final_cnt_ready", {15'd0, ready}, 16'd1);
    chk("final_cnt_start", start_cnt, saved_cnt);
    $display("final-count re-entry: ready=%0b busy=%0b", ready, busy);

    // Reset mid-RUN stops the clock at once.
    rst = 1'b1;
    tick();
    n_starts = 0;
    chk("midrst_d1", {15'd0, d1}, 16'd0);
    chk("midrst_ready", {15'd0, ready}, 16'd0);
    chk("midrst_busy", {15'd0, busy}, 16'd0);
    chk("midrst_start", start_cnt, 16'd0);
    $display("reset in run: d1=%0b busy=%0b ready=%0b", d1, busy, ready);
    rst = 1'b0;
    warm_up("post_rst");
    cool_down("post_rst");
    warm_up("s5");
    cool_down("s5");
    warm_up("s6");
    cool_down("s6");
    chk("three_sessions", start_cnt, exp_start(n_starts));
    $display("sessions: start_cnt=%0d", start_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
